// File: rtl/disp_arbiter.sv
// Two-source display ownership arbiter feeding a six-digit multiplexer.
// Optional DISP_ARB_PRIO0_EN gives source 0 fixed priority; otherwise round-robin with minimum hold.
module disp_arbiter #(
  parameter int          HOLD_CYC  = 25_000_000,
  parameter logic [7:0]  BLANK_PAT = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [47:0] frame0,
  input  logic [47:0] frame1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [7:0]  in0,
  output logic [7:0]  in1,
  output logic [7:0]  in2,
  output logic [7:0]  in3,
  output logic [7:0]  in4,
  output logic [7:0]  in5,
  output logic        busy
);

  localparam int CW = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, GAP} state_t;

  state_t        state, nxt;
  logic          rr, rr_nxt;   // last served source
  logic [CW-1:0] cnt;
  logic          hold_done;
  logic [47:0]   src;

  assign hold_done = (cnt == CW'(HOLD_CYC - 1));

  always_comb begin
    nxt    = state;
    rr_nxt = rr;
    case (state)
      IDLE: begin
`ifdef DISP_ARB_PRIO0_EN
        if (req0)      nxt = OWN0;
        else if (req1) nxt = OWN1;
`else
        if (req0 && req1) nxt = rr ? OWN0 : OWN1;
        else if (req0)    nxt = OWN0;
        else if (req1)    nxt = OWN1;
`endif
      end
      OWN0: begin
        if (!req0) begin
          nxt    = IDLE;
          rr_nxt = 1'b0;
        end
`ifndef DISP_ARB_PRIO0_EN
        else if (hold_done && req1) begin
          nxt    = GAP;
          rr_nxt = 1'b0;
        end
`endif
      end
      OWN1: begin
        if (!req1) begin
          nxt    = IDLE;
          rr_nxt = 1'b1;
        end
`ifdef DISP_ARB_PRIO0_EN
        else if (req0) begin
`else
        else if (hold_done && req0) begin
`endif
          nxt    = GAP;
          rr_nxt = 1'b1;
        end
      end
      GAP: begin
        // hand over to whichever source was not just served
        if (rr) nxt = req0 ? OWN0 : IDLE;
        else    nxt = req1 ? OWN1 : IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    src = {6{BLANK_PAT}};
    if (state == OWN0)      src = frame0;
    else if (state == OWN1) src = frame1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rr    <= 1'b1;
      cnt   <= '0;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      busy  <= 1'b0;
      in0   <= BLANK_PAT;
      in1   <= BLANK_PAT;
      in2   <= BLANK_PAT;
      in3   <= BLANK_PAT;
      in4   <= BLANK_PAT;
      in5   <= BLANK_PAT;
    end else begin
      state <= nxt;
      rr    <= rr_nxt;
      if (nxt != state)
        cnt <= '0;
      else if (!hold_done && (state == OWN0 || state == OWN1))
        cnt <= cnt + CW'(1);
      gnt0  <= (nxt == OWN0);
      gnt1  <= (nxt == OWN1);
      busy  <= (nxt == OWN0) || (nxt == OWN1);
      in0   <= src[7:0];
      in1   <= src[15:8];
      in2   <= src[23:16];
      in3   <= src[31:24];
      in4   <= src[39:32];
      in5   <= src[47:40];
    end
  end

endmodule

// File: tb/tb_disp_arbiter.sv
// Bench for disp_arbiter: directed vector table plus randomized run against a cycle-level ownership model.
module tb_disp_arbiter;
  localparam int HOLD = 4;
  localparam logic [7:0] BLANK = 8'hFF;

  logic clk = 0;
  logic rst_n, req0, req1;
  logic [47:0] frame0, frame1;
  logic gnt0, gnt1, busy;
  logic [7:0] in0, in1, in2, in3, in4, in5;

  int checks = 0, errors = 0;

  disp_arbiter #(.HOLD_CYC(HOLD), .BLANK_PAT(BLANK)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .frame0(frame0), .frame1(frame1), .gnt0(gnt0), .gnt1(gnt1),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3), .in4(in4), .in5(in5),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst_n, r0, r1;
    logic g0, g1, bsy;
    int   dsel;   // 0 blank, 1 frame0, 2 frame1
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic rs, logic a, logic b, logic g0, logic g1, int d);
    vec_t v;
    v.rst_n = rs; v.r0 = a; v.r1 = b; v.g0 = g0; v.g1 = g1; v.bsy = g0 | g1; v.dsel = d;
    tbl.push_back(v);
  endfunction

  function automatic logic [47:0] digits();
    return {in5, in4, in3, in2, in1, in0};
  endfunction

  task automatic check(string name, int idx, logic g0, logic g1, logic bsy, logic [47:0] dig);
    checks++;
    if ({gnt0, gnt1, busy} !== {g0, g1, bsy}) begin
      errors++;
      $display("FAIL %s[%0d] grants: got g0=%b g1=%b busy=%b want g0=%b g1=%b busy=%b",
               name, idx, gnt0, gnt1, busy, g0, g1, bsy);
    end
    checks++;
    if (digits() !== dig) begin
      errors++;
      $display("FAIL %s[%0d] digits: got %h want %h", name, idx, digits(), dig);
    end
  endtask

  // reference model state: own = -1 idle, 0/1 owner, 2 handover gap
  int own, held, last;

  task automatic model_step(logic rs, logic a, logic b, logic [47:0] f0, logic [47:0] f1,
                            output logic g0, output logic g1, output logic [47:0] dig);
    int nxt;
    logic r [2];
    r[0] = a; r[1] = b;
    if (!rs) begin
      own = -1; held = 0; last = 1; dig = {6{BLANK}};
    end else begin
      dig = (own == 0) ? f0 : (own == 1) ? f1 : {6{BLANK}};
      nxt = own;
      if (own == -1) begin
`ifdef DISP_ARB_PRIO0_EN
        nxt = a ? 0 : b ? 1 : -1;
`else
        if (a && b) nxt = 1 - last;
        else nxt = a ? 0 : b ? 1 : -1;
`endif
      end else if (own == 2) begin
        nxt = r[1 - last] ? 1 - last : -1;
      end else begin
        if (!r[own]) begin
          nxt = -1; last = own;
        end else begin
`ifdef DISP_ARB_PRIO0_EN
          if (own == 1 && a) begin nxt = 2; last = 1; end
`else
          if (held >= HOLD - 1 && r[1 - own]) begin nxt = 2; last = own; end
`endif
        end
      end
      held = (nxt == own) ? held + 1 : 0;
      own = nxt;
    end
    g0 = (own == 0);
    g1 = (own == 1);
  endtask

  initial begin
    logic [47:0] f [3];
    logic eg0, eg1;
    logic [47:0] edig;
    logic rs, a, b;

    rst_n = 0; req0 = 0; req1 = 0;
    frame0 = 48'h0102_0304_0506;
    frame1 = 48'h1112_1314_1516;
    f[0] = {6{BLANK}}; f[1] = frame0; f[2] = frame1;

`ifndef DISP_ARB_PRIO0_EN
    add(0,0,0, 0,0,0);                         // reset
    for (int i = 0; i < 4; i++) add(1,1,1, 1,0, i == 0 ? 0 : 1);  // OWN0 hold
    add(1,1,1, 0,0,1);                         // gap
    for (int i = 0; i < 4; i++) add(1,1,1, 0,1, i == 0 ? 0 : 2);  // OWN1 hold
    add(1,1,1, 0,0,2);                         // gap
    add(1,1,1, 1,0,0);                         // back to OWN0, cnt 0
    add(1,1,0, 1,0,1);                         // cnt 1
    add(1,0,1, 0,0,1);                         // owner drops -> idle
    add(1,0,1, 0,1,0);                         // OWN1
    for (int i = 0; i < 10; i++) add(1,0,1, 0,1,2);  // saturated hold, no gap
    add(0,1,1, 0,0,0);                         // reset mid-OWN1
    add(1,1,1, 1,0,0);                         // tie after reset -> source 0
    add(1,0,0, 0,0,1);
    add(1,0,0, 0,0,0);
    add(1,0,1, 0,1,0);
    add(1,0,0, 0,0,2);                         // last served 1
    add(1,1,1, 1,0,0);                         // tie -> 0
    add(1,0,0, 0,0,1);                         // last served 0
    add(1,1,1, 0,1,0);                         // tie -> 1

    for (int i = 0; i < tbl.size(); i++) begin
      rst_n = tbl[i].rst_n; req0 = tbl[i].r0; req1 = tbl[i].r1;
      @(posedge clk); #1;
      check("vec", i, tbl[i].g0, tbl[i].g1, tbl[i].bsy, f[tbl[i].dsel]);
    end
`endif

    // live pass-through: a frame edit during ownership shows one cycle later
    rst_n = 0; req0 = 0; req1 = 0;
    @(posedge clk); #1;
    rst_n = 1; req1 = 1;
    @(posedge clk); #1;
    frame1 = 48'hA1A2_A3A4_A5A6;
    @(posedge clk); #1;
    check("live", 0, 1'b0, 1'b1, 1'b1, 48'hA1A2_A3A4_A5A6);
    frame1 = 48'hB1B2_B3B4_B5B6;
    @(posedge clk); #1;
    check("live", 1, 1'b0, 1'b1, 1'b1, 48'hB1B2_B3B4_B5B6);

    // randomized run against the ownership model
    for (int i = 0; i < 400; i++) begin
      rs = (i == 0) ? 1'b0 : ($urandom_range(0, 49) != 0);
      a  = ($urandom_range(0, 3) != 0);
      b  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) a = 0;
      rst_n = rs; req0 = a; req1 = b;
      frame0 = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
      frame1 = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
      model_step(rs, a, b, frame0, frame1, eg0, eg1, edig);
      @(posedge clk); #1;
      check("rand", i, eg0, eg1, eg0 | eg1, edig);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
